dmac_buffer_credit_ctr: RTL and testbench
=========================================

Name: dmac_buffer_credit_ctr

Overview:
- Multi-channel buffer occupancy tracker for the DMA channel buffers.
- Each channel keeps a saturating occupancy count.
- Each cycle, one channel can be incremented and one channel (same or different) decremented, by a variable count.
- Generates per-channel empty/full/almost-full flags, sticky overflow/underflow error flags and per-channel flush.
- Sits between buffer write/read control and the channel arbiter, which uses the flags for admission.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- MAX_ELEMENTS, 16, capacity of each channel buffer in elements.
- AFULL_LEVEL, 12, almost-full flag asserts when usage >= AFULL_LEVEL (must be <= MAX_ELEMENTS).
- Derived, not overridable: CW = $clog2(MAX_ELEMENTS+1); CHW = max(1, $clog2(NUM_CH)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- inc_valid  in  1  increment request this cycle.
- inc_ch  in  CHW  channel to increment.
- inc_count  in  CW  elements added.
- dec_valid  in  1  decrement request this cycle.
- dec_ch  in  CHW  channel to decrement.
- dec_count  in  CW  elements removed.
- flush  in  NUM_CH  per-channel synchronous clear of usage.
- err_clr  in  1  clears all sticky error flags.
- usage  out  NUM_CH*CW  packed usage; channel i at bits [i*CW +: CW].
- free_cnt  out  NUM_CH*CW  MAX_ELEMENTS - usage, per channel, same packing.
- empty  out  NUM_CH  usage == 0.
- full  out  NUM_CH  usage == MAX_ELEMENTS.
- afull  out  NUM_CH  usage >= AFULL_LEVEL.
- err_ovf  out  NUM_CH  sticky overflow flag.
- err_udf  out  NUM_CH  sticky underflow flag.

Behaviour:
- Reset (rst_n low, asynchronous): all usage = 0; free_cnt = MAX_ELEMENTS; empty = all 1; full = 0; afull = 0 (all 1 if AFULL_LEVEL == 0); err_ovf = 0; err_udf = 0.
- Latency: all outputs are registered and update on the clk edge after the request. No combinational path from inputs to outputs.
- Per channel c, each cycle:
  - a = inc_valid && inc_ch == c ? inc_count : 0.
  - d = dec_valid && dec_ch == c ? dec_count : 0.
  - n = usage[c] + a - d, evaluated signed in CW+2 bits.
- Same-channel inc and dec in one cycle are netted (e.g. +3 and -3 gives no change). No error is raised unless the net result is out of range.
- n > MAX_ELEMENTS: usage saturates at MAX_ELEMENTS and err_ovf[c] is set.
- n < 0: usage clamps to 0 and err_udf[c] is set.
- A zero count with valid asserted is a legal no-op.
- inc_ch or dec_ch >= NUM_CH: request ignored, no error raised.
- flush[c] has priority over inc/dec on channel c: next usage = 0 and no error is raised for c that cycle. Other channels are unaffected.
- err_clr clears all err flags. If an error occurs in the same cycle as err_clr, the new error wins and the flag stays 1.
- empty, full, afull and free_cnt are derived from the registered next usage, so they are always consistent with usage in the same cycle.
- Reset asserted mid-operation discards any in-flight update. No state survives reset.

Optional Feature:
- Macro: DMAC_BUF_CTR_PEAK_EN.
- Defined: adds output peak (NUM_CH*CW, same packing as usage), the per-channel high-water mark.
  - peak[c] <= max(peak[c], next usage[c]).
  - Cleared to 0 by reset.
  - Set to the current next usage by flush[c] or err_clr.
- Undefined: no peak port and no peak registers. All other behaviour is identical.

Test Plan:
- Reset, then idle -> usage = 0 on all channels; empty = 4'b1111; free_cnt = 16 each; all err = 0.
- Channel 1: inc 5 for 3 cycles -> usage[1] = 5, 10, 15 one cycle after each request; afull[1] = 1 once usage reaches 15 (AFULL_LEVEL 12); full[1] = 0.
- Channel 2 at usage 14: inc 5 -> usage[2] = 16, full[2] = 1, err_ovf[2] = 1. Then err_clr -> err_ovf[2] = 0 while usage stays 16.
- Channel 0 at usage 4: same-cycle inc 3 and dec 7 -> usage 0, empty[0] = 1, no error. Next cycle dec 1 -> usage 0, err_udf[0] = 1.
- Channel 3 at usage 8: flush[3] with same-cycle inc 4 on ch3 and dec 2 on ch1 (usage 10) -> usage[3] = 0, usage[1] = 8, no errors.
- With DMAC_BUF_CTR_PEAK_EN defined: ch0 inc 9, dec 6, inc 2 -> peak[0] = 9 and usage[0] = 5. Then assert rst_n low mid-sequence -> all usage and peak = 0 immediately.

Source files
------------

// File: rtl/dmac_buffer_credit_ctr_if.sv
// Bus bundle for dmac_buffer_credit_ctr: inc/dec/flush requests in, occupancy and flags out.
// The peak port exists only when DMAC_BUF_CTR_PEAK_EN is defined.
interface dmac_buffer_credit_ctr_if #(
    parameter int NUM_CH       = 4,
    parameter int MAX_ELEMENTS = 16
);
    localparam int CW  = $clog2(MAX_ELEMENTS + 1);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                 inc_valid;
    logic [CHW-1:0]       inc_ch;
    logic [CW-1:0]        inc_count;
    logic                 dec_valid;
    logic [CHW-1:0]       dec_ch;
    logic [CW-1:0]        dec_count;
    logic [NUM_CH-1:0]    flush;
    logic                 err_clr;
    logic [NUM_CH*CW-1:0] usage;
    logic [NUM_CH*CW-1:0] free_cnt;
    logic [NUM_CH-1:0]    empty;
    logic [NUM_CH-1:0]    full;
    logic [NUM_CH-1:0]    afull;
    logic [NUM_CH-1:0]    err_ovf;
    logic [NUM_CH-1:0]    err_udf;
`ifdef DMAC_BUF_CTR_PEAK_EN
    logic [NUM_CH*CW-1:0] peak;
`endif

    modport master (
        output inc_valid, inc_ch, inc_count, dec_valid, dec_ch, dec_count, flush, err_clr,
`ifdef DMAC_BUF_CTR_PEAK_EN
        input  peak,
`endif
        input  usage, free_cnt, empty, full, afull, err_ovf, err_udf
    );

    modport slave (
        input  inc_valid, inc_ch, inc_count, dec_valid, dec_ch, dec_count, flush, err_clr,
`ifdef DMAC_BUF_CTR_PEAK_EN
        output peak,
`endif
        output usage, free_cnt, empty, full, afull, err_ovf, err_udf
    );
endinterface

// File: rtl/dmac_buffer_credit_ctr.sv
// Per-channel saturating buffer occupancy counters with flags; DMAC_BUF_CTR_PEAK_EN adds high-water marks.
// Latency: one cycle, every output registered from the next-state usage.
// Backpressure: none; requests are always accepted, out-of-range results clamp and raise sticky errors.
module dmac_buffer_credit_ctr #(
    parameter int NUM_CH       = 4,
    parameter int MAX_ELEMENTS = 16,
    parameter int AFULL_LEVEL  = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    dmac_buffer_credit_ctr_if.slave  bus
);
    localparam int CW  = $clog2(MAX_ELEMENTS + 1);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CW-1:0]        MAX_C   = CW'(MAX_ELEMENTS);
    localparam logic [CW-1:0]        AFULL_C = CW'(AFULL_LEVEL);
    localparam logic signed [CW+1:0] MAX_S   = (CW+2)'(MAX_ELEMENTS);

    logic [NUM_CH*CW-1:0] usage_q, usage_d;
    logic [NUM_CH*CW-1:0] free_q,  free_d;
    logic [NUM_CH-1:0]    empty_q, empty_d;
    logic [NUM_CH-1:0]    full_q,  full_d;
    logic [NUM_CH-1:0]    afull_q, afull_d;
    logic [NUM_CH-1:0]    ovf_q,   ovf_d;
    logic [NUM_CH-1:0]    udf_q,   udf_d;
`ifdef DMAC_BUF_CTR_PEAK_EN
    logic [NUM_CH*CW-1:0] peak_q,  peak_d;
`endif

    always_comb begin
        logic [CW-1:0]        a;
        logic [CW-1:0]        d;
        logic [CW-1:0]        u;
        logic signed [CW+1:0] n;
        logic                 ovf_hit;
        logic                 udf_hit;
`ifdef DMAC_BUF_CTR_PEAK_EN
        logic [CW-1:0]        p;
        p       = '0;
        peak_d  = peak_q;
`endif
        a       = '0;
        d       = '0;
        u       = '0;
        n       = '0;
        ovf_hit = 1'b0;
        udf_hit = 1'b0;
        usage_d = usage_q;
        free_d  = free_q;
        empty_d = empty_q;
        full_d  = full_q;
        afull_d = afull_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        for (int c = 0; c < NUM_CH; c++) begin
            // Channel indices >= NUM_CH never match any c, so such requests fall away silently.
            a = (bus.inc_valid && bus.inc_ch == CHW'(c)) ? bus.inc_count : '0;
            d = (bus.dec_valid && bus.dec_ch == CHW'(c)) ? bus.dec_count : '0;
            n = $signed({2'b00, usage_q[c*CW +: CW]}) + $signed({2'b00, a}) - $signed({2'b00, d});
            ovf_hit = 1'b0;
            udf_hit = 1'b0;
            if (bus.flush[c]) begin
                u = '0;
            end else if (n > MAX_S) begin
                u       = MAX_C;
                ovf_hit = 1'b1;
            end else if (n[CW+1]) begin
                u       = '0;
                udf_hit = 1'b1;
            end else begin
                u = n[CW-1:0];
            end
            usage_d[c*CW +: CW] = u;
            free_d[c*CW +: CW]  = MAX_C - u;
            empty_d[c]          = (u == '0);
            full_d[c]           = (u == MAX_C);
            afull_d[c]          = (u >= AFULL_C);
            // A fresh error in the clearing cycle must survive the clear.
            ovf_d[c] = (ovf_q[c] & ~bus.err_clr) | ovf_hit;
            udf_d[c] = (udf_q[c] & ~bus.err_clr) | udf_hit;
`ifdef DMAC_BUF_CTR_PEAK_EN
            p = peak_q[c*CW +: CW];
            if (bus.flush[c] || bus.err_clr) peak_d[c*CW +: CW] = u;
            else                             peak_d[c*CW +: CW] = (u > p) ? u : p;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            usage_q <= '0;
            free_q  <= {NUM_CH{MAX_C}};
            empty_q <= '1;
            full_q  <= '0;
            afull_q <= {NUM_CH{AFULL_LEVEL == 0}};
            ovf_q   <= '0;
            udf_q   <= '0;
`ifdef DMAC_BUF_CTR_PEAK_EN
            peak_q  <= '0;
`endif
        end else begin
            usage_q <= usage_d;
            free_q  <= free_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
`ifdef DMAC_BUF_CTR_PEAK_EN
            peak_q  <= peak_d;
`endif
        end
    end

    assign bus.usage    = usage_q;
    assign bus.free_cnt = free_q;
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.afull    = afull_q;
    assign bus.err_ovf  = ovf_q;
    assign bus.err_udf  = udf_q;
`ifdef DMAC_BUF_CTR_PEAK_EN
    assign bus.peak     = peak_q;
`endif
endmodule

// File: tb/tb_dmac_buffer_credit_ctr.sv
// Bench for dmac_buffer_credit_ctr: directed scenarios plus randomized traffic against an integer model.
module tb_dmac_buffer_credit_ctr;
    localparam int NCH  = 4;
    localparam int MAXE = 16;
    localparam int AFL  = 12;
    localparam int CW   = 5;
    localparam int CHW  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    int m_use  [NCH];
    int m_peak [NCH];
    bit m_ovf  [NCH];
    bit m_udf  [NCH];

    always #5 clk = ~clk;

    dmac_buffer_credit_ctr_if #(.NUM_CH(NCH), .MAX_ELEMENTS(MAXE)) bus ();

    dmac_buffer_credit_ctr #(.NUM_CH(NCH), .MAX_ELEMENTS(MAXE), .AFULL_LEVEL(AFL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [CW-1:0] use_of(int c);
        return bus.usage[c*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] free_of(int c);
        return bus.free_cnt[c*CW +: CW];
    endfunction

`ifdef DMAC_BUF_CTR_PEAK_EN
    function automatic logic [CW-1:0] peak_of(int c);
        return bus.peak[c*CW +: CW];
    endfunction
`endif

    task automatic set_idle();
        bus.inc_valid = 1'b0; bus.inc_ch = '0; bus.inc_count = '0;
        bus.dec_valid = 1'b0; bus.dec_ch = '0; bus.dec_count = '0;
        bus.flush = '0; bus.err_clr = 1'b0;
    endtask

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            m_use[c] = 0; m_peak[c] = 0; m_ovf[c] = 0; m_udf[c] = 0;
        end
    endtask

    // Drive one request cycle, advance the model at the edge, sample 1 time unit later.
    task automatic cyc(input bit iv, input int ich, input int icnt,
                       input bit dv, input int dch, input int dcnt,
                       input logic [NCH-1:0] fl, input bit ec);
        bus.inc_valid = iv; bus.inc_ch = CHW'(ich); bus.inc_count = CW'(icnt);
        bus.dec_valid = dv; bus.dec_ch = CHW'(dch); bus.dec_count = CW'(dcnt);
        bus.flush = fl; bus.err_clr = ec;
        @(posedge clk);
        for (int c = 0; c < NCH; c++) begin
            int n;
            bit eo, eu;
            n  = m_use[c] + ((iv && ich == c) ? icnt : 0) - ((dv && dch == c) ? dcnt : 0);
            eo = 0; eu = 0;
            if (fl[c])          n = 0;
            else if (n > MAXE) begin n = MAXE; eo = 1; end
            else if (n < 0)    begin n = 0;    eu = 1; end
            m_use[c] = n;
            m_ovf[c] = (ec ? 1'b0 : m_ovf[c]) | eo;
            m_udf[c] = (ec ? 1'b0 : m_udf[c]) | eu;
            m_peak[c] = (fl[c] || ec) ? n : ((n > m_peak[c]) ? n : m_peak[c]);
        end
        #1;
        set_idle();
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < NCH; c++) begin
            tests++; if (use_of(c) !== 5'd0) begin fails++; $display("FAIL reset usage[%0d]: got %0d expected 0", c, use_of(c)); end
            tests++; if (free_of(c) !== 5'd16) begin fails++; $display("FAIL reset free_cnt[%0d]: got %0d expected 16", c, free_of(c)); end
        end
        tests++; if (bus.empty !== 4'b1111) begin fails++; $display("FAIL reset empty: got %b expected 1111", bus.empty); end
        tests++; if (bus.full !== 4'b0000 || bus.afull !== 4'b0000) begin fails++; $display("FAIL reset full/afull: got %b/%b expected 0000/0000", bus.full, bus.afull); end
        tests++; if (bus.err_ovf !== 4'b0000 || bus.err_udf !== 4'b0000) begin fails++; $display("FAIL reset err: got %b/%b expected 0000/0000", bus.err_ovf, bus.err_udf); end
    endtask

    task automatic test_inc_afull();
        int exp_u [3] = '{5, 10, 15};
        for (int k = 0; k < 3; k++) begin
            cyc(1, 1, 5, 0, 0, 0, 4'b0000, 0);
            tests++; if (use_of(1) !== CW'(exp_u[k])) begin fails++; $display("FAIL inc usage[1] step %0d: got %0d expected %0d", k, use_of(1), exp_u[k]); end
            tests++; if (bus.afull[1] !== (k == 2)) begin fails++; $display("FAIL inc afull[1] step %0d: got %b expected %b", k, bus.afull[1], k == 2); end
        end
        tests++; if (bus.full[1] !== 1'b0 || bus.empty[1] !== 1'b0) begin fails++; $display("FAIL inc full/empty[1]: got %b/%b expected 0/0", bus.full[1], bus.empty[1]); end
        tests++; if (free_of(1) !== 5'd1) begin fails++; $display("FAIL inc free_cnt[1]: got %0d expected 1", free_of(1)); end
    endtask

    task automatic test_overflow();
        cyc(1, 2, 14, 0, 0, 0, 4'b0000, 0);
        tests++; if (use_of(2) !== 5'd14 || bus.err_ovf[2] !== 1'b0) begin fails++; $display("FAIL ovf preload usage/ovf[2]: got %0d/%b expected 14/0", use_of(2), bus.err_ovf[2]); end
        cyc(1, 2, 5, 0, 0, 0, 4'b0000, 0);
        tests++; if (use_of(2) !== 5'd16) begin fails++; $display("FAIL ovf usage[2]: got %0d expected 16", use_of(2)); end
        tests++; if (bus.full[2] !== 1'b1 || bus.err_ovf[2] !== 1'b1) begin fails++; $display("FAIL ovf full/err_ovf[2]: got %b/%b expected 1/1", bus.full[2], bus.err_ovf[2]); end
        tests++; if (free_of(2) !== 5'd0) begin fails++; $display("FAIL ovf free_cnt[2]: got %0d expected 0", free_of(2)); end
        cyc(0, 0, 0, 0, 0, 0, 4'b0000, 1);
        tests++; if (bus.err_ovf[2] !== 1'b0 || use_of(2) !== 5'd16) begin fails++; $display("FAIL err_clr ovf/usage[2]: got %b/%0d expected 0/16", bus.err_ovf[2], use_of(2)); end
        cyc(1, 2, 1, 0, 0, 0, 4'b0000, 1);
        tests++; if (bus.err_ovf[2] !== 1'b1) begin fails++; $display("FAIL err_clr collision ovf[2]: got %b expected 1", bus.err_ovf[2]); end
        cyc(0, 0, 0, 0, 0, 0, 4'b0000, 1);
    endtask

    task automatic test_net_underflow();
        cyc(1, 0, 4, 0, 0, 0, 4'b0000, 0);
        cyc(1, 0, 3, 1, 0, 7, 4'b0000, 0);
        tests++; if (use_of(0) !== 5'd0 || bus.empty[0] !== 1'b1) begin fails++; $display("FAIL net usage/empty[0]: got %0d/%b expected 0/1", use_of(0), bus.empty[0]); end
        tests++; if (bus.err_udf[0] !== 1'b0 || bus.err_ovf[0] !== 1'b0) begin fails++; $display("FAIL net err[0]: got %b/%b expected 0/0", bus.err_ovf[0], bus.err_udf[0]); end
        cyc(0, 0, 0, 1, 0, 1, 4'b0000, 0);
        tests++; if (use_of(0) !== 5'd0 || bus.err_udf[0] !== 1'b1) begin fails++; $display("FAIL udf usage/err_udf[0]: got %0d/%b expected 0/1", use_of(0), bus.err_udf[0]); end
        cyc(1, 3, 2, 0, 0, 0, 4'b0000, 0);
        cyc(1, 3, 0, 1, 3, 0, 4'b0000, 0);
        tests++; if (use_of(3) !== 5'd2 || bus.err_udf[0] !== 1'b1) begin fails++; $display("FAIL zero-count usage[3]/sticky udf[0]: got %0d/%b expected 2/1", use_of(3), bus.err_udf[0]); end
        cyc(1, 3, 3, 1, 3, 3, 4'b0000, 1);
        tests++; if (use_of(3) !== 5'd2 || bus.err_udf !== 4'b0000) begin fails++; $display("FAIL cancel usage[3]/err_udf: got %0d/%b expected 2/0000", use_of(3), bus.err_udf); end
    endtask

    task automatic test_flush();
        cyc(1, 3, 6, 1, 1, 5, 4'b0000, 0);
        tests++; if (use_of(3) !== 5'd8 || use_of(1) !== 5'd10) begin fails++; $display("FAIL flush preload usage[3]/[1]: got %0d/%0d expected 8/10", use_of(3), use_of(1)); end
        cyc(1, 3, 4, 1, 1, 2, 4'b1000, 0);
        tests++; if (use_of(3) !== 5'd0 || use_of(1) !== 5'd8) begin fails++; $display("FAIL flush usage[3]/[1]: got %0d/%0d expected 0/8", use_of(3), use_of(1)); end
        tests++; if (use_of(2) !== 5'd16) begin fails++; $display("FAIL flush bystander usage[2]: got %0d expected 16", use_of(2)); end
        tests++; if (bus.err_ovf !== 4'b0000 || bus.err_udf !== 4'b0000) begin fails++; $display("FAIL flush err: got %b/%b expected 0000/0000", bus.err_ovf, bus.err_udf); end
        cyc(0, 0, 0, 1, 3, 5, 4'b1000, 0);
        tests++; if (bus.err_udf[3] !== 1'b0) begin fails++; $display("FAIL flush masks udf[3]: got %b expected 0", bus.err_udf[3]); end
    endtask

`ifdef DMAC_BUF_CTR_PEAK_EN
    task automatic test_peak();
        cyc(0, 0, 0, 0, 0, 0, 4'b1111, 1);
        cyc(1, 0, 9, 0, 0, 0, 4'b0000, 0);
        cyc(0, 0, 0, 1, 0, 6, 4'b0000, 0);
        cyc(1, 0, 2, 0, 0, 0, 4'b0000, 0);
        tests++; if (peak_of(0) !== 5'd9 || use_of(0) !== 5'd5) begin fails++; $display("FAIL peak/usage[0]: got %0d/%0d expected 9/5", peak_of(0), use_of(0)); end
        cyc(0, 0, 0, 0, 0, 0, 4'b0000, 1);
        tests++; if (peak_of(0) !== 5'd5) begin fails++; $display("FAIL peak err_clr reload[0]: got %0d expected 5", peak_of(0)); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            logic [NCH-1:0] fl;
            fl = ($urandom_range(0, 12) == 0) ? NCH'($urandom_range(0, 15)) : '0;
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, NCH-1), $urandom_range(0, 20),
                $urandom_range(0, 3) != 0, $urandom_range(0, NCH-1), $urandom_range(0, 20),
                fl, $urandom_range(0, 15) == 0);
            for (int c = 0; c < NCH; c++) begin
                tests++;
                if (use_of(c) !== CW'(m_use[c]) || free_of(c) !== CW'(MAXE - m_use[c])) begin
                    fails++; $display("FAIL rand %0d usage/free[%0d]: got %0d/%0d expected %0d/%0d", i, c, use_of(c), free_of(c), m_use[c], MAXE - m_use[c]);
                end
                tests++;
                if (bus.empty[c] !== (m_use[c] == 0) || bus.full[c] !== (m_use[c] == MAXE) || bus.afull[c] !== (m_use[c] >= AFL)) begin
                    fails++; $display("FAIL rand %0d flags[%0d]: got e%b f%b af%b for usage %0d", i, c, bus.empty[c], bus.full[c], bus.afull[c], m_use[c]);
                end
                tests++;
                if (bus.err_ovf[c] !== m_ovf[c] || bus.err_udf[c] !== m_udf[c]) begin
                    fails++; $display("FAIL rand %0d err[%0d]: got %b/%b expected %b/%b", i, c, bus.err_ovf[c], bus.err_udf[c], m_ovf[c], m_udf[c]);
                end
`ifdef DMAC_BUF_CTR_PEAK_EN
                tests++;
                if (peak_of(c) !== CW'(m_peak[c])) begin
                    fails++; $display("FAIL rand %0d peak[%0d]: got %0d expected %0d", i, c, peak_of(c), m_peak[c]);
                end
`endif
            end
        end
    endtask

    task automatic test_reset_mid();
        cyc(1, 1, 7, 0, 0, 0, 4'b0000, 0);
        cyc(1, 2, 3, 0, 0, 0, 4'b0000, 0);
        bus.inc_valid = 1'b1; bus.inc_ch = 2'd0; bus.inc_count = 5'd9;
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        for (int c = 0; c < NCH; c++) begin
            tests++; if (use_of(c) !== 5'd0 || free_of(c) !== 5'd16) begin fails++; $display("FAIL midreset usage/free[%0d]: got %0d/%0d expected 0/16", c, use_of(c), free_of(c)); end
`ifdef DMAC_BUF_CTR_PEAK_EN
            tests++; if (peak_of(c) !== 5'd0) begin fails++; $display("FAIL midreset peak[%0d]: got %0d expected 0", c, peak_of(c)); end
`endif
        end
        tests++; if (bus.empty !== 4'b1111 || bus.err_ovf !== 4'b0000) begin fails++; $display("FAIL midreset empty/ovf: got %b/%b expected 1111/0000", bus.empty, bus.err_ovf); end
        @(posedge clk); #1;
        tests++; if (use_of(0) !== 5'd0) begin fails++; $display("FAIL midreset held usage[0]: got %0d expected 0", use_of(0)); end
        set_idle();
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        set_idle();
        model_clear();
        test_reset();
        test_inc_afull();
        test_overflow();
        test_net_underflow();
        test_flush();
`ifdef DMAC_BUF_CTR_PEAK_EN
        test_peak();
`endif
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
